// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory responder and its helpers.
// Holds the FSM state type, word geometry and the latency counter sizing so
// the instruction-side responder can reuse the same building blocks.
package dmem_pkg;

    // Responder FSM: waiting for a request, or counting down an access.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Data word width of the load/store interface.
    localparam int WORD_W     = 32;

    // Number of byte-offset bits inside a word address.
    localparam int BYTE_OFF_W = 2;

    // Largest supported access latency and the counter width that covers it.
    localparam int LAT_MAX    = 15;
    localparam int LAT_CNT_W  = $clog2(LAT_MAX + 1);

    // True when a byte address does not point at the start of a word.
    function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
        return addr[BYTE_OFF_W-1:0] != '0;
    endfunction

endpackage : dmem_pkg

// File: rtl/dmem_lat_counter.sv
// Loadable down-counter with a zero flag.
// Loaded with (latency - 1) when an access is accepted, then decremented each
// busy cycle; the zero flag marks the acknowledge cycle. Stops at zero rather
// than wrapping so a stray decrement can never restart a countdown.
module dmem_lat_counter
    import dmem_pkg::*;
#(
    parameter int W = LAT_CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load wins over a decrement; decrement stops at zero.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : dmem_lat_counter

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store interface.
// One word access at a time: the request is latched on acceptance, the
// pipeline is stalled while the latency counter runs, and the access
// completes with a single-cycle acknowledge. Stores commit at the end of the
// acknowledge cycle, so a following load always sees the new value.
// Misaligned or out-of-range accesses complete normally but flag err_o and
// neither read nor write the array.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY = 3,    // request acceptance to acknowledge, 1..15
    parameter int DEPTH   = 256,  // storage words, power of two
    parameter int CNT_W   = 16    // width of the saturating access counters
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              stall_o,
    output logic              ack_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  rd_count_o,
    output logic [CNT_W-1:0]  wr_count_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TOP_W = WORD_W - IDX_W - BYTE_OFF_W;

    // Counter preload: the acceptance cycle itself is the first latency cycle.
    localparam logic [LAT_CNT_W-1:0] LOAD_VAL = LAT_CNT_W'(LATENCY - 1);

    // Request latched at acceptance; inputs are ignored while busy.
    state_e            state_q;
    logic              we_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic              err_q;

    logic [CNT_W-1:0]  rd_cnt_q;
    logic [CNT_W-1:0]  rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q;
    logic [CNT_W-1:0]  wr_cnt_d;

    logic [WORD_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              busy;
    logic              cnt_zero;
    logic              ack_cycle;
    logic              req_err;
    logic [IDX_W-1:0]  req_idx;
    logic [TOP_W-1:0]  req_top;

    // Address decode of the incoming request.
    assign req_idx = addr_i[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
    assign req_top = addr_i[WORD_W-1:IDX_W+BYTE_OFF_W];
    assign req_err = is_misaligned(addr_i) || (req_top != '0);

    assign busy      = (state_q == BUSY);
    assign accept    = (state_q == IDLE) && req_valid_i;
    assign ack_cycle = busy && cnt_zero;

    dmem_lat_counter #(
        .W (LAT_CNT_W)
    ) u_lat_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (accept),
        .load_val_i (LOAD_VAL),
        .dec_i      (busy),
        .zero_o     (cnt_zero)
    );

    // Responder FSM: latch the request on accept, return to IDLE after ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        state_q <= BUSY;
                        we_q    <= req_we_i;
                        idx_q   <= req_idx;
                        wdata_q <= wdata_i;
                        err_q   <= req_err;
                    end
                end
                BUSY: begin
                    if (cnt_zero) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage array: a store commits at the close of its acknowledge cycle.
    always_ff @(posedge clk_i) begin
        // NOTE: the array has no reset; clearing it would need a write port
        // per word, and software never relies on its power-up contents.
        if (!rst_i && ack_cycle && we_q && !err_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Saturating completion counters; errored accesses still count.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (ack_cycle && !we_q && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (ack_cycle && we_q && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Handshake outputs, decoded from registered state and forced low in reset.
    always_comb begin
        stall_o = 1'b0;
        ack_o   = 1'b0;
        err_o   = 1'b0;
        rdata_o = '0;
        if (!rst_i) begin
            if (busy) begin
                stall_o = !cnt_zero;
                ack_o   = cnt_zero;
                err_o   = cnt_zero && err_q;
                if (cnt_zero && !we_q && !err_q) begin
                    rdata_o = mem_q[idx_q];
                end
            end else begin
                stall_o = req_valid_i;
            end
        end
    end

    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a directed back-to-back vector table, a reset
// abort sequence, randomized traffic against a word-array reference model,
// and a second build with LATENCY=1 and 2-bit counters for saturation.
module tb_dmem_responder;

    localparam int LAT   = 3;
    localparam int DEPTH = 256;
    localparam int CNT_W = 16;

    logic        clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Main instance (LATENCY=3, DEPTH=256).
    logic        rst_i, req_valid_i, req_we_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, ack_o, err_o;
    logic [31:0] rdata_o;
    logic [CNT_W-1:0] rd_count_o, wr_count_o;

    dmem_responder #(.LATENCY(LAT), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i),
        .req_we_i(req_we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o),
        .rd_count_o(rd_count_o), .wr_count_o(wr_count_o)
    );

    // Small instance (LATENCY=1, DEPTH=16, 2-bit counters).
    logic        s_rst_i, s_req_valid_i, s_req_we_i;
    logic [31:0] s_addr_i, s_wdata_i;
    logic        s_stall_o, s_ack_o, s_err_o;
    logic [31:0] s_rdata_o;
    logic [1:0]  s_rd_count_o, s_wr_count_o;

    dmem_responder #(.LATENCY(1), .DEPTH(16), .CNT_W(2)) dut_small (
        .clk_i(clk_i), .rst_i(s_rst_i), .req_valid_i(s_req_valid_i),
        .req_we_i(s_req_we_i), .addr_i(s_addr_i), .wdata_i(s_wdata_i),
        .stall_o(s_stall_o), .ack_o(s_ack_o), .rdata_o(s_rdata_o),
        .err_o(s_err_o), .rd_count_o(s_rd_count_o), .wr_count_o(s_wr_count_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word array plus saturating completion counts.
    logic [31:0] model_mem [DEPTH];
    int unsigned m_rd = 0;
    int unsigned m_wr = 0;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    function automatic bit spec_err(input logic [31:0] addr);
        return (addr % 4 != 0) || (addr >= 4 * DEPTH);
    endfunction

    // One access on the main instance: request visible now (just after an
    // edge); checks stall/ack for every cycle up to the ack, scrambles the
    // inputs while busy, and leaves req_valid_i high if chain is set.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit chain, input logic exp_err, input logic [31:0] exp_rdata);
        req_valid_i = 1'b1;
        req_we_i    = we;
        addr_i      = addr;
        wdata_i     = wdata;
        for (int c = 0; c <= LAT; c++) begin
            @(negedge clk_i);
            if (c == 0) begin
                check("rd_count", 32'(rd_count_o), m_rd);
                check("wr_count", 32'(wr_count_o), m_wr);
            end
            check("stall", 32'(stall_o), 32'(c < LAT));
            check("ack", 32'(ack_o), 32'(c == LAT));
            if (c == LAT) begin
                check("err", 32'(err_o), 32'(exp_err));
                check("rdata", rdata_o, exp_rdata);
            end
            @(posedge clk_i);
            #1;
            if (c == 0) begin
                req_we_i = 1'($urandom_range(0, 1));
                addr_i   = $urandom;
                wdata_i  = $urandom;
            end
        end
        if (!chain) req_valid_i = 1'b0;
        if (we) begin
            if (!spec_err(addr)) model_mem[addr / 4] = wdata;
            if (m_wr < CNT_MAX) m_wr++;
        end else begin
            if (m_rd < CNT_MAX) m_rd++;
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        bit          e;
        logic [31:0] exp_rd;

        vecs[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 32'h14,  32'h12345678, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h14,  32'h0,        1'b0, 32'h12345678};
        vecs[4] = '{1'b0, 32'h13,  32'h0,        1'b1, 32'h0};
        vecs[5] = '{1'b1, 32'h0,   32'h11111111, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 32'h400, 32'hCAFEF00D, 1'b1, 32'h0};
        vecs[7] = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h11111111};

        // Reset with a request pending: everything must stay quiet.
        rst_i = 1'b1; req_valid_i = 1'b1; req_we_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0;
        s_rst_i = 1'b1; s_req_valid_i = 1'b0; s_req_we_i = 1'b0;
        s_addr_i = 32'h0; s_wdata_i = 32'h0;
        @(negedge clk_i);
        check("reset stall", 32'(stall_o), 32'h0);
        check("reset ack", 32'(ack_o), 32'h0);
        check("reset err", 32'(err_o), 32'h0);
        check("reset rdata", rdata_o, 32'h0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0; req_valid_i = 1'b0;
        @(negedge clk_i);
        check("post-reset stall", 32'(stall_o), 32'h0);
        check("post-reset rd_count", 32'(rd_count_o), 32'h0);
        check("post-reset wr_count", 32'(wr_count_o), 32'h0);
        @(posedge clk_i); #1;

        // Directed table, all back-to-back with req_valid_i held high.
        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, i != 7,
                   vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // Reset in the middle of a store: abandoned, no ack, no commit.
        do_req(1'b1, 32'h8, 32'h77777777, 1'b0, 1'b0, 32'h0);
        req_valid_i = 1'b1; req_we_i = 1'b1; addr_i = 32'h8; wdata_i = 32'hAAAA5555;
        @(negedge clk_i);
        check("abort stall T", 32'(stall_o), 32'h1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("abort stall in reset", 32'(stall_o), 32'h0);
        check("abort ack in reset", 32'(ack_o), 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; req_valid_i = 1'b0;
        m_rd = 0; m_wr = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            check("abort no ack", 32'(ack_o), 32'h0);
            check("abort no stall", 32'(stall_o), 32'h0);
            @(posedge clk_i); #1;
        end
        do_req(1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h77777777);

        // Fill words 0..15 so random loads have known contents.
        for (int i = 0; i < 16; i++) begin
            do_req(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b0, 32'h0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                1:       a = 32'(4 * DEPTH + $urandom_range(0, 4000));
                default: a = 32'($urandom_range(0, 15) * 4);
            endcase
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            e = spec_err(a);
            exp_rd = (e || w) ? 32'h0 : model_mem[a / 4];
            do_req(w, a, d, 1'($urandom_range(0, 1)), e, exp_rd);
        end
        @(negedge clk_i);
        check("final rd_count", 32'(rd_count_o), m_rd);
        check("final wr_count", 32'(wr_count_o), m_wr);
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;

        // LATENCY=1 build: one store, then five loads to saturate rd_count.
        s_rst_i = 1'b0;
        s_req_valid_i = 1'b1; s_req_we_i = 1'b1; s_addr_i = 32'h4; s_wdata_i = 32'h5A5A5A5A;
        @(negedge clk_i);
        check("lat1 store stall", 32'(s_stall_o), 32'h1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("lat1 store ack", 32'(s_ack_o), 32'h1);
        check("lat1 store ack stall", 32'(s_stall_o), 32'h0);
        @(posedge clk_i); #1;
        s_req_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_req_valid_i = 1'b1; s_req_we_i = 1'b0; s_addr_i = 32'h4;
            @(negedge clk_i);
            check("lat1 load stall T", 32'(s_stall_o), 32'h1);
            check("lat1 load ack T", 32'(s_ack_o), 32'h0);
            @(posedge clk_i); #1;
            s_addr_i = 32'h3C;
            @(negedge clk_i);
            check("lat1 load ack T+1", 32'(s_ack_o), 32'h1);
            check("lat1 load stall T+1", 32'(s_stall_o), 32'h0);
            check("lat1 load rdata", s_rdata_o, 32'h5A5A5A5A);
            @(posedge clk_i); #1;
            s_req_valid_i = 1'b0;
            @(negedge clk_i);
            check("lat1 rd_count sat", 32'(s_rd_count_o), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
            check("lat1 wr_count", 32'(s_wr_count_o), 32'd1);
            @(posedge clk_i); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dmem_responder

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the pipeline's MEM-stage load/store interface.
- Accepts one word request at a time from the EX/MEM register, holds the pipeline with a stall while the access is in flight, then returns read data or commits the write with a one-cycle acknowledge.
- Replaces the zero-latency data memory so the CPU can be exercised against realistic memory timing.

Parameters:
- LATENCY, 3: cycles from request acceptance to acknowledge; legal range 1..15.
- DEPTH, 256: number of 32-bit words in the storage array; power of two.
- CNT_W, 16: width of the saturating transaction counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  load or store requested this cycle (MEM-stage MemRead | MemWrite)
- req_we_i  in  1  1 = store, 0 = load
- addr_i  in  32  byte address (ALU result)
- wdata_i  in  32  store data
- stall_o  out  1  freeze PC/IFID/IDEX/EXMEM/MEMWB this cycle
- ack_o  out  1  access completes this cycle
- rdata_o  out  32  load data, valid only when ack_o=1
- err_o  out  1  completed access was misaligned or out of range (qualifies ack_o)
- rd_count_o  out  CNT_W  completed loads, saturating
- wr_count_o  out  CNT_W  completed stores, saturating

Behaviour:
- FSM states: IDLE, BUSY. A down-counter cnt is loaded on accept.
- Reset (rst_i=1 at a clock edge): state=IDLE, cnt=0, latched request cleared, both counters=0.
  - stall_o, ack_o, err_o and rdata_o are forced 0 in any cycle where rst_i=1.
  - The storage array is not cleared.
- IDLE:
  - stall_o = req_valid_i (combinational); ack_o=0; rdata_o=0; err_o=0.
  - If req_valid_i=1: latch we/addr/wdata, load cnt=LATENCY-1, go to BUSY.
- BUSY, cnt!=0: stall_o=1, ack_o=0, cnt decrements. Inputs are ignored; the requester holds them stable, but the responder uses only the latched copy.
- BUSY, cnt==0 (acknowledge cycle): stall_o=0, ack_o=1, next state IDLE.
  - Load: rdata_o = mem[addr[log2(DEPTH)+1:2]].
  - Store: mem written at the closing edge of this cycle; rdata_o=0.
  - Completed load increments rd_count_o, completed store increments wr_count_o; both saturate at all-ones.
- Timing: a request first seen at cycle T gives ack at T+LATENCY and stall high for cycles T..T+LATENCY-1.
- Back-to-back requests: the pipeline advances on the ack cycle, so the next request is sampled in IDLE at T+LATENCY+1. There is no acceptance in the ack cycle itself, which avoids re-accepting the same instruction.
- Error cases, both complete normally with err_o=1 alongside ack_o, rdata_o=0, no write, and counters still incremented:
  - misaligned: addr[1:0]!=0
  - out of range: addr >= 4*DEPTH
- Reset mid-BUSY: the access is abandoned, the store is not committed, no ack is issued.
- Store-then-load to the same word: the load observes the stored value, since the write commits before the next accept.

Decomposition:
- Shared package dmem_pkg:
  - state enum (IDLE, BUSY)
  - WORD_W=32
  - address helper constants (byte-offset bits = 2)
- Natural sub-module: dmem_lat_counter
  - Loadable down-counter with a zero flag, width $clog2(16).
  - Reused later by the instruction-side responder.

Test Plan (LATENCY=3, DEPTH=256):
- Store 0xDEADBEEF @0x10 at T=0 -> stall_o=1 at T=0,1,2; ack_o=1 at T=3, err_o=0; wr_count_o=1. A following load @0x10 acks at T+3 with rdata_o=0xDEADBEEF.
- Load from preloaded mem[5]=0x12345678 (addr 0x14) with addr_i changed to 0x20 during BUSY -> ack with rdata_o=0x12345678 (latched address used).
- Misaligned load at 0x13 -> ack at T+3 with err_o=1, rdata_o=0. Out-of-range store at 0x400 -> err_o=1 and mem unchanged.
- Store 0xAAAA5555 @0x8 with rst_i pulsed at T+1 -> no ack; stall_o=0 during reset; mem[2] keeps its old value; counters=0.
- Back-to-back load, store, load with req_valid_i held high -> acks at T+3, T+7, T+11; stall low only in the ack cycles and the single IDLE gap is absent because each new request stalls immediately.
- LATENCY=1 build with a single load -> stall_o only at T, ack_o at T+1. Set CNT_W=2 and issue 5 loads -> rd_count_o saturates at 3.
